// File: rtl/beam_sweep_scheduler.sv
// Ping sequencer for the sonar datapath: burst, listen, report, stepping the
// beam angle across a sweep and handing one (angle, range, hit) record per ping.
module beam_sweep_scheduler #(
  parameter int PERIOD_CYCLES = 16777216,
  parameter int BURST_CYCLES  = 524288,
  parameter int ANGLE_WIDTH   = 8,
  parameter int ANGLE_MIN     = -30,
  parameter int ANGLE_MAX     = 30,
  parameter int ANGLE_STEP    = 10,
  parameter int RANGE_WIDTH   = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          enable_in,
  input  logic                          tof_valid_in,
  input  logic [RANGE_WIDTH-1:0]        range_in,
  input  logic                          result_ready_in,
  output logic                          burst_active_out,
  output logic                          burst_start_out,
  output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
  output logic                          result_valid_out,
  output logic signed [ANGLE_WIDTH-1:0] result_angle_out,
  output logic [RANGE_WIDTH-1:0]        result_range_out,
  output logic                          result_hit_out,
  output logic                          sweep_done_out
);

  localparam int CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(BURST_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic signed [ANGLE_WIDTH-1:0] ANGLE_FIRST = ANGLE_WIDTH'(ANGLE_MIN);
  localparam logic signed [ANGLE_WIDTH:0]   ANGLE_LIMIT = (ANGLE_WIDTH+1)'(ANGLE_MAX);
  localparam logic signed [ANGLE_WIDTH:0]   ANGLE_INC   = (ANGLE_WIDTH+1)'(ANGLE_STEP);

  typedef enum logic [1:0] {IDLE, BURST, LISTEN, REPORT} state_t;

  state_t                          state, state_d;
  logic [CNT_W-1:0]                count, count_d;
  logic                            cap_hit, cap_hit_d;
  logic [RANGE_WIDTH-1:0]          cap_range, cap_range_d;
  logic                            burst_active_d, burst_start_d;
  logic signed [ANGLE_WIDTH-1:0]   angle_d;
  logic                            valid_d;
  logic signed [ANGLE_WIDTH-1:0]   r_angle_d;
  logic [RANGE_WIDTH-1:0]          r_range_d;
  logic                            r_hit_d;
  logic                            sweep_done_d;
  logic signed [ANGLE_WIDTH:0]     angle_sum;

  // One extra bit so stepping past the top of the signed range cannot wrap silently
  assign angle_sum = $signed({beam_angle_out[ANGLE_WIDTH-1], beam_angle_out}) + ANGLE_INC;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state            <= IDLE;
      count            <= '0;
      cap_hit          <= 1'b0;
      cap_range        <= '0;
      burst_active_out <= 1'b0;
      burst_start_out  <= 1'b0;
      beam_angle_out   <= ANGLE_FIRST;
      result_valid_out <= 1'b0;
      result_angle_out <= '0;
      result_range_out <= '0;
      result_hit_out   <= 1'b0;
      sweep_done_out   <= 1'b0;
    end else begin
      state            <= state_d;
      count            <= count_d;
      cap_hit          <= cap_hit_d;
      cap_range        <= cap_range_d;
      burst_active_out <= burst_active_d;
      burst_start_out  <= burst_start_d;
      beam_angle_out   <= angle_d;
      result_valid_out <= valid_d;
      result_angle_out <= r_angle_d;
      result_range_out <= r_range_d;
      result_hit_out   <= r_hit_d;
      sweep_done_out   <= sweep_done_d;
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop
  always_comb begin
    state_d        = state;
    count_d        = count;
    cap_hit_d      = cap_hit;
    cap_range_d    = cap_range;
    burst_active_d = 1'b0;
    burst_start_d  = 1'b0;
    angle_d        = beam_angle_out;
    valid_d        = result_valid_out;
    r_angle_d      = result_angle_out;
    r_range_d      = result_range_out;
    r_hit_d        = result_hit_out;
    sweep_done_d   = 1'b0;

    case (state)
      IDLE: begin
        if (enable_in) begin
          state_d        = BURST;
          count_d        = '0;
          burst_active_d = 1'b1;
          burst_start_d  = 1'b1;
        end
      end

      BURST: begin
        count_d = count + CNT_W'(1);
        if (count == BURST_LAST) begin
          state_d = LISTEN;
        end else begin
          burst_active_d = 1'b1;
        end
      end

      LISTEN: begin
        if (tof_valid_in && !cap_hit) begin
          cap_hit_d   = 1'b1;
          cap_range_d = range_in;
        end
        if (count == PERIOD_LAST) begin
          state_d   = REPORT;
          valid_d   = 1'b1;
          r_angle_d = beam_angle_out;
          r_range_d = cap_range_d;
          r_hit_d   = cap_hit_d;
        end else begin
          count_d = count + CNT_W'(1);
        end
      end

      REPORT: begin
        if (result_ready_in) begin
          valid_d     = 1'b0;
          r_angle_d   = '0;
          r_range_d   = '0;
          r_hit_d     = 1'b0;
          cap_hit_d   = 1'b0;
          cap_range_d = '0;
          if (angle_sum > ANGLE_LIMIT) begin
            angle_d      = ANGLE_FIRST;
            sweep_done_d = 1'b1;
          end else begin
            angle_d = angle_sum[ANGLE_WIDTH-1:0];
          end
          if (enable_in) begin
            state_d        = BURST;
            count_d        = '0;
            burst_active_d = 1'b1;
            burst_start_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_beam_sweep_scheduler.sv
// Self-checking bench for beam_sweep_scheduler with a short ping period and a
// ping-level reference model (expected angle sequence and first-hit record).
module tb_beam_sweep_scheduler;

  localparam int PERIOD = 40;
  localparam int BURST  = 8;
  localparam int AMIN   = -30;
  localparam int AMAX   = 30;
  localparam int ASTEP  = 10;

  logic              clock;
  logic              resetN;
  logic              enable;
  logic              tofValid;
  logic [15:0]       rangeIn;
  logic              resultReady;
  logic              burstActive;
  logic              burstStart;
  logic signed [7:0] beamAngle;
  logic              resultValid;
  logic signed [7:0] resultAngle;
  logic [15:0]       resultRange;
  logic              resultHit;
  logic              sweepDone;

  int checks   = 0;
  int failures = 0;
  int angleIdx = 0;
  int pulseK[$];
  logic [15:0] pulseR[$];

  beam_sweep_scheduler #(
    .PERIOD_CYCLES(PERIOD),
    .BURST_CYCLES (BURST),
    .ANGLE_WIDTH  (8),
    .ANGLE_MIN    (AMIN),
    .ANGLE_MAX    (AMAX),
    .ANGLE_STEP   (ASTEP),
    .RANGE_WIDTH  (16)
  ) dut (
    .clk_in          (clock),
    .rst_in          (resetN),
    .enable_in       (enable),
    .tof_valid_in    (tofValid),
    .range_in        (rangeIn),
    .result_ready_in (resultReady),
    .burst_active_out(burstActive),
    .burst_start_out (burstStart),
    .beam_angle_out  (beamAngle),
    .result_valid_out(resultValid),
    .result_angle_out(resultAngle),
    .result_range_out(resultRange),
    .result_hit_out  (resultHit),
    .sweep_done_out  (sweepDone)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives the inputs seen by the DUT at ping counter k
  task automatic applyStimulus(input int k, input int dropAt);
    tofValid = 1'b0;
    rangeIn  = 16'($urandom);
    foreach (pulseK[i]) begin
      if (pulseK[i] == k && !tofValid) begin
        tofValid = 1'b1;
        rangeIn  = pulseR[i];
      end
    end
    enable = (dropAt >= 0 && k >= dropAt) ? 1'b0 : 1'b1;
  endtask

  function automatic int angleOf(input int idx);
    return AMIN + idx * ASTEP;
  endfunction

  // Starts at the first BURST cycle of a ping and ends one cycle after accept
  task automatic runPing(input int readyDelay, input bit enAccept, input int dropAt);
    int expAngle;
    int hitK;
    logic [15:0] expRange;
    bit expHit;
    bit wrap;
    expAngle = angleOf(angleIdx);
    expHit   = 1'b0;
    expRange = 16'h0;
    hitK     = PERIOD;
    foreach (pulseK[i]) begin
      if (pulseK[i] >= BURST && pulseK[i] < hitK) begin
        hitK     = pulseK[i];
        expRange = pulseR[i];
        expHit   = 1'b1;
      end
    end

    for (int k = 0; k < PERIOD; k++) begin
      checkOutput("burst_active", burstActive, k < BURST);
      checkOutput("burst_start", burstStart, k == 0);
      checkOutput("beam_angle", beamAngle, expAngle);
      checkOutput("valid_in_ping", resultValid, 0);
      if (k > 0) checkOutput("sweep_done_in_ping", sweepDone, 0);
      applyStimulus(k, dropAt);
      tick();
    end

    for (int d = 0; d <= readyDelay; d++) begin
      checkOutput("rep_valid", resultValid, 1);
      checkOutput("rep_angle", resultAngle, expAngle);
      checkOutput("rep_range", resultRange, expRange);
      checkOutput("rep_hit", resultHit, expHit);
      checkOutput("rep_beam_angle", beamAngle, expAngle);
      checkOutput("rep_burst_active", burstActive, 0);
      checkOutput("rep_burst_start", burstStart, 0);
      resultReady = (d == readyDelay);
      enable      = (d == readyDelay) ? enAccept : 1'($urandom_range(0, 1));
      tofValid    = 1'($urandom_range(0, 1));
      rangeIn     = 16'($urandom);
      tick();
    end
    tofValid = 1'b0;

    wrap     = (expAngle + ASTEP > AMAX);
    angleIdx = wrap ? 0 : angleIdx + 1;
    checkOutput("post_valid", resultValid, 0);
    checkOutput("post_sweep_done", sweepDone, wrap);
    checkOutput("post_angle", beamAngle, angleOf(angleIdx));
    checkOutput("post_burst_start", burstStart, enAccept);
    pulseK.delete();
    pulseR.delete();
  endtask

  initial begin
    resetN      = 1'b0;
    enable      = 1'b0;
    tofValid    = 1'b0;
    rangeIn     = 16'h0;
    resultReady = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_burst_active", burstActive, 0);
    checkOutput("rst_burst_start", burstStart, 0);
    checkOutput("rst_angle", beamAngle, AMIN);
    checkOutput("rst_valid", resultValid, 0);
    checkOutput("rst_range", resultRange, 0);
    checkOutput("rst_hit", resultHit, 0);
    checkOutput("rst_sweep_done", sweepDone, 0);

    @(negedge clock);
    resetN = 1'b1;
    tick();
    checkOutput("idle_no_burst", burstActive, 0);

    enable      = 1'b1;
    resultReady = 1'b1;
    tick();

    $display("[TB] first hit wins, later pulse ignored");
    pulseK.push_back(20); pulseR.push_back(16'h0123);
    pulseK.push_back(25); pulseR.push_back(16'h0456);
    runPing(0, 1'b1, -1);

    $display("[TB] no echo");
    runPing(0, 1'b1, -1);

    $display("[TB] burst ring-down ignored, last listen cycle captured");
    pulseK.push_back(3);  pulseR.push_back(16'($urandom));
    pulseK.push_back(39); pulseR.push_back(16'h0077);
    runPing(0, 1'b1, -1);

    $display("[TB] consumer stall");
    pulseK.push_back(30); pulseR.push_back(16'hBEEF);
    runPing(100, 1'b1, -1);

    $display("[TB] enable dropped mid-listen");
    pulseK.push_back(12); pulseR.push_back(16'h1111);
    runPing(0, 1'b0, 15);
    for (int i = 0; i < 3; i++) begin
      checkOutput("idle_burst_active", burstActive, 0);
      checkOutput("idle_burst_start", burstStart, 0);
      checkOutput("idle_angle", beamAngle, angleOf(angleIdx));
      tick();
    end
    enable = 1'b1;
    tick();

    $display("[TB] randomized sweep");
    for (int p = 0; p < 10; p++) begin
      int n;
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        pulseK.push_back($urandom_range(0, PERIOD - 1));
        pulseR.push_back(16'($urandom));
      end
      runPing($urandom_range(0, 3), 1'b1, -1);
    end

    $display("[TB] asynchronous reset mid-burst");
    repeat (4) tick();
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("arst_burst_active", burstActive, 0);
    checkOutput("arst_burst_start", burstStart, 0);
    checkOutput("arst_angle", beamAngle, AMIN);
    checkOutput("arst_valid", resultValid, 0);
    checkOutput("arst_result_angle", resultAngle, 0);
    checkOutput("arst_range", resultRange, 0);
    checkOutput("arst_hit", resultHit, 0);
    checkOutput("arst_sweep_done", sweepDone, 0);
    @(negedge clock);
    resetN   = 1'b1;
    angleIdx = 0;
    tick();
    pulseK.push_back(10); pulseR.push_back(16'h0ABC);
    runPing(1, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
